// File: rtl/demux5_hold.sv
// demux5_hold: 1-to-5 registered demultiplexer with per-slot valid/ack
// handshake, plus a sticky illegal-select flag and saturating drop counter.

// One holding slot: a data register and a valid bit with consumer ack.
module demux5_slot #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             ack,
   output logic [WIDTH-1:0] data,
   output logic             valid
);
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   // Write wins over ack so an ack plus accept on one edge keeps the slot full.
   // Data is left untouched on ack; only the valid bit drops.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (wr) begin
         data_d  = din;
         valid_d = 1'b1;
      end else if (ack && valid_q) begin
         valid_d = 1'b0;
      end
   end

   // Slot state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
endmodule

module demux5_hold #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic [2:0]       sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [4:0]       out_valid,
   input  logic [4:0]       out_ack,
   input  logic             clr_err,
   output logic             sel_err,
   output logic [CNT_W-1:0] drop_cnt
);
   localparam int NUM_SLOTS = 5;

   logic [NUM_SLOTS-1:0]            sel_oh;
   logic [NUM_SLOTS-1:0]            slot_free;
   logic [NUM_SLOTS-1:0]            slot_wr;
   logic [NUM_SLOTS-1:0][WIDTH-1:0] slot_data;
   logic                            sel_legal;
   logic                            accept;
   logic                            acc_ill;

   logic             sel_err_q, sel_err_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] cnt_base;

   // One-hot decode of sel; selects 5..7 decode to all zeros.
   genvar k;
   generate
      for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
         assign sel_oh[k]    = (sel == 3'(k));
         assign slot_free[k] = !out_valid[k] || out_ack[k];
         assign slot_wr[k]   = accept && sel_oh[k];

         demux5_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (slot_wr[k]),
            .din   (din),
            .ack   (out_ack[k]),
            .data  (slot_data[k]),
            .valid (out_valid[k])
         );
      end
   endgenerate

   assign sel_legal = |sel_oh;
   // Illegal words are always taken (and dropped); legal ones wait for room.
   assign in_ready  = rst_n && (!sel_legal || |(sel_oh & slot_free));
   assign accept    = in_valid && in_ready;
   assign acc_ill   = accept && !sel_legal;

   // Clear applies before the increment, so clear plus illegal accept gives 1.
   always_comb begin
      cnt_base   = clr_err ? '0 : drop_cnt_q;
      drop_cnt_d = cnt_base;
      if (acc_ill && (cnt_base != {CNT_W{1'b1}}))
         drop_cnt_d = cnt_base + CNT_W'(1);
      sel_err_d  = (clr_err ? 1'b0 : sel_err_q) || acc_ill;
   end

   // Debug error state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         sel_err_q  <= sel_err_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign sel_err  = sel_err_q;
   assign drop_cnt = drop_cnt_q;
   assign out1     = slot_data[0];
   assign out2     = slot_data[1];
   assign out3     = slot_data[2];
   assign out4     = slot_data[3];
   assign out5     = slot_data[4];
endmodule

// File: tb/tb_demux5_hold.sv
// Scoreboard bench for demux5_hold: each driven cycle pushes the expected
// output snapshot, which is popped and compared after the clock edge.
module tb_demux5_hold;
   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   typedef struct {
      logic [4:0][WIDTH-1:0] data;
      logic [4:0]            valid;
      logic                  err;
      logic [CNT_W-1:0]      cnt;
   } snap_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [2:0]       sel = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out1, out2, out3, out4, out5;
   logic [4:0]       out_valid;
   logic [4:0]       out_ack = '0;
   logic             clr_err = 1'b0;
   logic             sel_err;
   logic [CNT_W-1:0] drop_cnt;

   int n_chk = 0;
   int n_err = 0;

   snap_t m;
   snap_t sb_q[$];

   demux5_hold #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
      .out5(out5), .out_valid(out_valid), .out_ack(out_ack), .clr_err(clr_err),
      .sel_err(sel_err), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m.data  = '0;
      m.valid = '0;
      m.err   = 1'b0;
      m.cnt   = '0;
   endtask

   task automatic cmp_outputs(input string tag, input snap_t e);
      chk({tag, ".out1"}, 32'(out1), 32'(e.data[0]));
      chk({tag, ".out2"}, 32'(out2), 32'(e.data[1]));
      chk({tag, ".out3"}, 32'(out3), 32'(e.data[2]));
      chk({tag, ".out4"}, 32'(out4), 32'(e.data[3]));
      chk({tag, ".out5"}, 32'(out5), 32'(e.data[4]));
      chk({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
      chk({tag, ".err"}, 32'(sel_err), 32'(e.err));
      chk({tag, ".cnt"}, 32'(drop_cnt), 32'(e.cnt));
   endtask

   // Drive one cycle, check in_ready, push expected next state, then compare.
   task automatic step(input string tag, input logic iv, input logic [2:0] s,
                       input logic [WIDTH-1:0] d, input logic [4:0] ack,
                       input logic clr);
      logic  exp_rdy;
      logic  legal;
      snap_t e;
      snap_t got_e;
      in_valid = iv; sel = s; din = d; out_ack = ack; clr_err = clr;
      #1;
      legal   = (s <= 3'd4);
      exp_rdy = legal ? (!m.valid[s] || ack[s]) : 1'b1;
      chk({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
      e = m;
      for (int k = 0; k < 5; k++) begin
         if (iv && exp_rdy && legal && (s == 3'(k))) begin
            e.data[k]  = d;
            e.valid[k] = 1'b1;
         end else if (ack[k]) begin
            e.valid[k] = 1'b0;
         end
      end
      if (clr) begin
         e.err = 1'b0;
         e.cnt = '0;
      end
      if (iv && !legal) begin
         e.err = 1'b1;
         if (e.cnt != {CNT_W{1'b1}}) e.cnt = e.cnt + 1'b1;
      end
      m = e;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         got_e = sb_q.pop_front();
         cmp_outputs(tag, got_e);
      end
      in_valid = 1'b0; out_ack = '0; clr_err = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      snap_t z;
      z.data = '0; z.valid = '0; z.err = 1'b0; z.cnt = '0;
      cmp_outputs(tag, z);
      chk({tag, ".rdy"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      model_clear();
      #3;
      check_reset("rst0");
      @(negedge clk); rst_n = 1'b1;
      #2;
      // Put some state in place, then hit reset asynchronously mid-cycle.
      step("pre_w4", 1'b1, 3'd3, 16'h7777, 5'b00000, 1'b0);
      step("pre_ill", 1'b1, 3'd6, 16'h1234, 5'b00000, 1'b0);
      #2;
      in_valid = 1'b1; sel = 3'd0; din = 16'hEEEE;
      rst_n = 1'b0;
      #1;
      check_reset("rst_async");
      in_valid = 1'b0;
      model_clear();
      @(posedge clk); #1;
      check_reset("rst_hold");
      @(negedge clk); rst_n = 1'b1;
      #2;

      // Basic fill.
      step("fill1", 1'b1, 3'd0, 16'hABCD, 5'b00000, 1'b0);
      step("fill2", 1'b1, 3'd1, 16'h0123, 5'b00000, 1'b0);

      // Backpressure on a full slot, then accept together with the ack.
      step("bp_stall", 1'b1, 3'd0, 16'h4567, 5'b00000, 1'b0);
      step("bp_ack", 1'b1, 3'd0, 16'h4567, 5'b00001, 1'b0);

      // One word per cycle through slot 3 with continuous ack.
      step("tp0", 1'b1, 3'd2, 16'h0000, 5'b00100, 1'b0);
      step("tp1", 1'b1, 3'd2, 16'h89EF, 5'b00100, 1'b0);
      step("tp2", 1'b1, 3'd2, 16'h1111, 5'b00100, 1'b0);
      step("tp3", 1'b1, 3'd2, 16'h2222, 5'b00100, 1'b0);
      step("tp4", 1'b1, 3'd2, 16'h3333, 5'b00100, 1'b0);
      step("tp_drain", 1'b0, 3'd2, 16'hDEAD, 5'b00100, 1'b0);
      step("tp_idle", 1'b0, 3'd4, 16'hBEEF, 5'b00000, 1'b0);

      // Illegal selects.
      step("ill5", 1'b1, 3'd5, 16'hAAAA, 5'b00000, 1'b0);
      step("ill6", 1'b1, 3'd6, 16'hBBBB, 5'b00000, 1'b0);
      step("ill7", 1'b1, 3'd7, 16'hCCCC, 5'b00000, 1'b0);
      step("ill_clr", 1'b1, 3'd7, 16'hDDDD, 5'b00000, 1'b1);

      // Saturation of the drop counter.
      for (int i = 0; i < 260; i++)
         step("sat", 1'b1, 3'(5 + (i % 3)), 16'(i), 5'b00000, 1'b0);
      step("sat_hold", 1'b0, 3'd5, 16'h0, 5'b00000, 1'b0);

      // Leave only slots 1 and 5 valid, then ack all five at once.
      step("ack2", 1'b0, 3'd0, 16'h0, 5'b00010, 1'b0);
      step("w5", 1'b1, 3'd4, 16'h5555, 5'b00000, 1'b0);
      step("ack_all", 1'b0, 3'd0, 16'h0, 5'b11111, 1'b0);
      step("after_ack", 1'b0, 3'd0, 16'h0, 5'b00000, 1'b0);

      // Clear error state without an illegal accept.
      step("clr_only", 1'b0, 3'd6, 16'h0, 5'b00000, 1'b1);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
